cm0_fetch_unit: RTL and testbench
=================================

# cm0_fetch_unit

Instruction-fetch front end and IF/ID pipeline register for the Cortex-M0 pipeline. It is the consumer of the hazard unit's `stall` and `flush` outputs. It also produces the `if_id_rs1`/`if_id_rs2` fields that the hazard unit compares. It issues 16-bit Thumb fetches over a req/ack instruction-memory interface with wait states, and holds or squashes the IF/ID register on hazards and redirects.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; bit 0 ignored.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: load-use stall from the hazard unit; hold PC and IF/ID.
- `flush` in 1: branch taken; squash IF/ID and redirect.
- `branch_target` in 32: redirect address, valid when `flush`=1.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, halfword aligned.
- `imem_ack` in 1: fetch complete; `imem_rdata` valid this cycle.
- `imem_rdata` in 16: fetched instruction.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `if_id_instr` out 16: registered instruction.
- `if_id_pc` out 32: address of `if_id_instr`.
- `if_id_rs1` out 4: {1'b0, `if_id_instr[5:3]`}.
- `if_id_rs2` out 4: {1'b0, `if_id_instr[8:6]`}.
  - Low-register formats only; hi-register extraction belongs to the decoder.

## Operation
- Registers:
  - `pc` (address of the current or next request).
  - `redir` (latched flush target).
  - One-entry hold buffer {`instr`, `pc`, `full`}.
  - IF/ID.
- States:
  - IDLE: reset, `imem_req`=0. Always goes to FETCH next cycle.
  - FETCH: `imem_req`=1, `imem_addr`=`pc`.
  - DRAIN: `imem_req`=1, `imem_addr`=`pc`, but the response is discarded.
  - HOLD: `imem_req`=0, buffer full.
- Protocol: once `imem_req` rises, it and `imem_addr` stay stable until the ack cycle. Ack is legal in the same cycle as req (zero wait).
- Priority: `flush` > `stall` > normal.
- FETCH transitions:
  - flush, ack=1: data dropped, `if_id_valid`<=0, `pc`<={`branch_target`[31:1],1'b0}, stay FETCH.
  - flush, ack=0: `if_id_valid`<=0, `redir`<=target, go DRAIN.
  - stall, ack=1: data and `pc` into the buffer, `pc`<=`pc`+2, IF/ID unchanged, go HOLD.
  - stall, ack=0: IF/ID unchanged, stay FETCH.
  - ack=1, no stall: IF/ID<={1, `rdata`, `pc`}, `pc`<=`pc`+2.
  - ack=0, no stall: `if_id_valid`<=0 (bubble).
- DRAIN transitions:
  - flush: `redir` updated to the newest target.
  - ack: data dropped, `pc`<=`redir`, go FETCH.
  - `if_id_valid` stays 0 throughout DRAIN.
- HOLD transitions:
  - flush: buffer cleared, `if_id_valid`<=0, `pc`<=target, go FETCH.
  - stall: stay HOLD.
  - else: IF/ID<=buffer, buffer cleared, go FETCH.
- `pc`+2 wraps modulo 2^32 (32'hFFFF_FFFE -> 0).

## Timing
- Reset values, asynchronous:
  - `imem_req`=0, `imem_addr`=`RESET_PC`, `pc`=`RESET_PC`, state IDLE.
  - `if_id_valid`=0; `if_id_instr`, `if_id_pc`, `if_id_rs1`, `if_id_rs2` all 0; buffer empty.
- First `imem_req` is in the second rising edge after `rst_n` deasserts.
- Ack to `if_id_valid`: 1 cycle.
- Zero-wait memory sustains one instruction per cycle.
- `stall` and `flush` are sampled on the same edge as `imem_ack`. No combinational path from `stall`/`flush` to `imem_req`/`imem_addr`; all outputs are registered.
- Flush to the first request at target: next cycle from FETCH or HOLD; the cycle after the pending ack from DRAIN.
- Reset mid-transaction: abandons the request; memory must tolerate req dropping on reset.

## Structure
- Shared package `cm0_pkg`:
  - `fetch_state_t` enum (IDLE, FETCH, DRAIN, HOLD).
  - `CM0_RESET_PC_DEFAULT`.
  - Low-register field positions `RS1_LSB`=3, `RS2_LSB`=6, reused by the decoder and the hazard unit.
- One natural sub-module: `cm0_if_id_reg`. It holds the IF/ID register and hold buffer, with load, hold and squash controls and field extraction. The FSM and PC stay in the top.

## Test plan
- Reset release, zero-wait memory returning `instr` = `addr[15:0]`:
  - First `imem_req` at cycle 2 with address 0.
  - Consecutive cycles show `if_id_pc` 0, 2, 4 and `if_id_valid`=1.
- Ack delayed 3 cycles on `addr` 0x10:
  - `imem_addr` stays 0x10 throughout.
  - `if_id_valid`=0 for 3 cycles, then `if_id_pc`=0x10.
- `stall`=1 for 2 cycles coinciding with an ack of 0x1234 at `pc` 0x20:
  - IF/ID unchanged during the stall, `imem_req`=0 in HOLD.
  - After release, `if_id_instr`=0x1234, `if_id_pc`=0x20, and the next fetch is at 0x22.
- `flush` with `branch_target`=0x101 while a fetch is waiting:
  - Late ack data never reaches IF/ID.
  - Next request is at 0x100.
  - `flush` and `stall` asserted together squash rather than hold.
- `RESET_PC`=32'hFFFF_FFFC, zero wait: fetch addresses FFFF_FFFC, FFFF_FFFE, 0000_0000.
- Instruction 0x01C8 (bits [5:3]=001, [8:6]=111): `if_id_rs1`=1, `if_id_rs2`=7.
- `rst_n` pulsed during DRAIN: all outputs return to reset values immediately, then fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/cm0_pkg.sv
// Shared Cortex-M0 pipeline definitions: fetch FSM encoding, reset vector,
// and the bit positions of the low-register fields inside a Thumb halfword.
package cm0_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] CM0_RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int RS1_LSB = 3;
    localparam int RS2_LSB = 6;

endpackage

// File: rtl/cm0_if_id_reg.sv
// IF/ID pipeline register plus a one-entry hold buffer that parks a fetch
// which completed while the pipeline was stalled.
module cm0_if_id_reg
    import cm0_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_load_buf,
    input  logic        i_squash,
    input  logic        i_buf_wr,
    input  logic        i_buf_clr,
    input  logic [15:0] i_instr,
    input  logic [31:0] i_pc,
    output logic        o_valid,
    output logic [15:0] o_instr,
    output logic [31:0] o_pc,
    output logic [3:0]  o_rs1,
    output logic [3:0]  o_rs2
);

    logic        r_valid;
    logic [15:0] r_instr;
    logic [31:0] r_pc;
    logic        r_buf_full;
    logic [15:0] r_buf_instr;
    logic [31:0] r_buf_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_instr     <= 16'h0000;
            r_pc        <= 32'h0000_0000;
            r_buf_full  <= 1'b0;
            r_buf_instr <= 16'h0000;
            r_buf_pc    <= 32'h0000_0000;
        end else begin
            // Squash only drops valid; stale instr/pc are harmless once invalid.
            if (i_squash) begin
                r_valid <= 1'b0;
            end else if (i_load) begin
                r_valid <= 1'b1;
                r_instr <= i_instr;
                r_pc    <= i_pc;
            end else if (i_load_buf && r_buf_full) begin
                r_valid <= 1'b1;
                r_instr <= r_buf_instr;
                r_pc    <= r_buf_pc;
            end

            if (i_buf_wr) begin
                r_buf_full  <= 1'b1;
                r_buf_instr <= i_instr;
                r_buf_pc    <= i_pc;
            end else if (i_buf_clr || i_load_buf) begin
                r_buf_full <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_rs1   = {1'b0, r_instr[RS1_LSB +: 3]};
    assign o_rs2   = {1'b0, r_instr[RS2_LSB +: 3]};

endmodule

// File: rtl/cm0_fetch_unit.sv
// Thumb instruction-fetch front end: req/ack fetch FSM, PC and redirect
// tracking, feeding the IF/ID register under hazard-unit stall/flush control.
module cm0_fetch_unit
    import cm0_pkg::*;
#(
    parameter logic [31:0] RESET_PC = CM0_RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        if_id_valid,
    output logic [15:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [3:0]  if_id_rs1,
    output logic [3:0]  if_id_rs2
);

    localparam logic [31:0] PC_INIT = RESET_PC & ~32'd1;

    fetch_state_t r_state, w_next_state;
    logic [31:0]  r_pc, w_pc_next;
    logic [31:0]  r_redir, w_redir_next;
    logic         r_req;
    logic [31:0]  w_pc_inc;
    logic [31:0]  w_target;
    logic         w_load, w_load_buf, w_squash, w_buf_wr, w_buf_clr;

    assign w_pc_inc = r_pc + 32'd2;
    assign w_target = branch_target & ~32'd1;

    always_comb begin
        w_next_state = r_state;
        w_pc_next    = r_pc;
        w_redir_next = r_redir;
        w_load       = 1'b0;
        w_load_buf   = 1'b0;
        w_squash     = 1'b0;
        w_buf_wr     = 1'b0;
        w_buf_clr    = 1'b0;
        case (r_state)
            IDLE: begin
                w_next_state = FETCH;
            end
            FETCH: begin
                if (flush) begin
                    w_squash = 1'b1;
                    if (imem_ack) begin
                        w_pc_next = w_target;
                    end else begin
                        // Request must stay stable until acked; remember where to go.
                        w_redir_next = w_target;
                        w_next_state = DRAIN;
                    end
                end else if (stall) begin
                    if (imem_ack) begin
                        w_buf_wr     = 1'b1;
                        w_pc_next    = w_pc_inc;
                        w_next_state = HOLD;
                    end
                end else if (imem_ack) begin
                    w_load    = 1'b1;
                    w_pc_next = w_pc_inc;
                end else begin
                    w_squash = 1'b1;
                end
            end
            DRAIN: begin
                if (flush) begin
                    w_redir_next = w_target;
                end
                if (imem_ack) begin
                    w_pc_next    = flush ? w_target : r_redir;
                    w_next_state = FETCH;
                end
            end
            HOLD: begin
                if (flush) begin
                    w_buf_clr    = 1'b1;
                    w_squash     = 1'b1;
                    w_pc_next    = w_target;
                    w_next_state = FETCH;
                end else if (!stall) begin
                    w_load_buf   = 1'b1;
                    w_next_state = FETCH;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pc    <= PC_INIT;
            r_redir <= PC_INIT;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_pc_next;
            r_redir <= w_redir_next;
            r_req   <= (w_next_state == FETCH) || (w_next_state == DRAIN);
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_pc;

    cm0_if_id_reg u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_buf (w_load_buf),
        .i_squash   (w_squash),
        .i_buf_wr   (w_buf_wr),
        .i_buf_clr  (w_buf_clr),
        .i_instr    (imem_rdata),
        .i_pc       (r_pc),
        .o_valid    (if_id_valid),
        .o_instr    (if_id_instr),
        .o_pc       (if_id_pc),
        .o_rs1      (if_id_rs1),
        .o_rs2      (if_id_rs2)
    );

endmodule

// File: tb/tb_cm0_fetch_unit.sv
// Directed bench for cm0_fetch_unit: wait states, stall/hold, flush/drain,
// PC wrap (second instance) and asynchronous reset mid-transaction.
module tb_cm0_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst_n_w, stall, flush;
    logic [31:0] branch_target;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        if_id_valid;
    logic [15:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [3:0]  if_id_rs1, if_id_rs2;

    logic        ack_auto, ack_man, rd_ov_en;
    logic [15:0] rd_ov;

    assign imem_ack   = ack_auto ? imem_req : ack_man;
    assign imem_rdata = rd_ov_en ? rd_ov : imem_addr[15:0];

    logic        w_req, w_ack;
    logic [31:0] w_addr;
    logic [15:0] w_rdata;
    logic        w_valid;
    logic [15:0] w_instr;
    logic [31:0] w_pc;
    logic [3:0]  w_rs1, w_rs2;
    logic        s_zero;
    logic [31:0] s_zero32;

    assign w_ack    = w_req;
    assign w_rdata  = w_addr[15:0];
    assign s_zero   = 1'b0;
    assign s_zero32 = 32'h0;

    cm0_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_id_valid(if_id_valid),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2)
    );

    cm0_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_n_w), .stall(s_zero), .flush(s_zero),
        .branch_target(s_zero32), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata), .if_id_valid(w_valid),
        .if_id_instr(w_instr), .if_id_pc(w_pc),
        .if_id_rs1(w_rs1), .if_id_rs2(w_rs2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   {31'b0, imem_req},    32'h0);
        chk({tag, "_addr"},  imem_addr,            32'h0);
        chk({tag, "_valid"}, {31'b0, if_id_valid}, 32'h0);
        chk({tag, "_instr"}, {16'b0, if_id_instr}, 32'h0);
        chk({tag, "_pc"},    if_id_pc,             32'h0);
        chk({tag, "_rs"},    {24'b0, if_id_rs1, if_id_rs2}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; rst_n_w = 1'b1; stall = 1'b0; flush = 1'b0;
        branch_target = 32'h0;
        ack_auto = 1'b1; ack_man = 1'b0; rd_ov_en = 1'b0; rd_ov = 16'h0;
        #1;
        rst_n = 1'b0; rst_n_w = 1'b0;
        #2;
        chk_reset_vals("rst");
        chk("rst_w_addr", w_addr, 32'hFFFF_FFFC);
        step; step;
        rst_n = 1'b1; rst_n_w = 1'b1;

        // Edge 1: IDLE -> FETCH, request visible for edge 2
        step;
        chk("e1_req",   {31'b0, imem_req}, 32'h1);
        chk("e1_addr",  imem_addr, 32'h0);
        chk("e1_valid", {31'b0, if_id_valid}, 32'h0);
        chk("w_e1_addr", w_addr, 32'hFFFF_FFFC);
        step;
        chk("e2_valid", {31'b0, if_id_valid}, 32'h1);
        chk("e2_pc",    if_id_pc, 32'h0);
        chk("e2_addr",  imem_addr, 32'h2);
        chk("w_e2_addr", w_addr, 32'hFFFF_FFFE);
        chk("w_e2_pc",   w_pc, 32'hFFFF_FFFC);
        step;
        chk("e3_pc",    if_id_pc, 32'h2);
        chk("e3_instr", {16'b0, if_id_instr}, 32'h2);
        chk("w_e3_addr", w_addr, 32'h0);
        chk("w_e3_pc",   w_pc, 32'hFFFF_FFFE);
        step;
        chk("e4_pc",    if_id_pc, 32'h4);
        chk("e4_valid", {31'b0, if_id_valid}, 32'h1);
        chk("w_e4_pc",  w_pc, 32'h0);

        // Three wait states on address 0x10
        for (int i = 0; i < 20 && imem_addr != 32'h10; i++) step;
        chk("reach_10", imem_addr, 32'h10);
        ack_auto = 1'b0; ack_man = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step;
            chk("ws_addr",  imem_addr, 32'h10);
            chk("ws_req",   {31'b0, imem_req}, 32'h1);
            chk("ws_valid", {31'b0, if_id_valid}, 32'h0);
        end
        ack_man = 1'b1;
        step;
        chk("ws_done_pc",    if_id_pc, 32'h10);
        chk("ws_done_valid", {31'b0, if_id_valid}, 32'h1);
        ack_auto = 1'b1; ack_man = 1'b0;

        // Stall for two cycles with an ack of 0x1234 at 0x20
        for (int i = 0; i < 20 && imem_addr != 32'h20; i++) step;
        chk("reach_20", imem_addr, 32'h20);
        stall = 1'b1; rd_ov_en = 1'b1; rd_ov = 16'h1234;
        step;
        chk("st1_req", {31'b0, imem_req}, 32'h0);
        chk("st1_pc",  if_id_pc, 32'h1E);
        chk("st1_valid", {31'b0, if_id_valid}, 32'h1);
        rd_ov_en = 1'b0;
        step;
        chk("st2_req", {31'b0, imem_req}, 32'h0);
        chk("st2_pc",  if_id_pc, 32'h1E);
        stall = 1'b0;
        step;
        chk("rel_instr", {16'b0, if_id_instr}, 32'h1234);
        chk("rel_pc",    if_id_pc, 32'h20);
        chk("rel_addr",  imem_addr, 32'h22);
        chk("rel_req",   {31'b0, imem_req}, 32'h1);
        step;
        chk("post_pc", if_id_pc, 32'h22);

        // Flush while a fetch is waiting; late ack data must be dropped
        ack_auto = 1'b0; ack_man = 1'b0;
        step;
        chk("fl_bubble", {31'b0, if_id_valid}, 32'h0);
        flush = 1'b1; branch_target = 32'h101;
        step;
        chk("fl_drain_addr",  imem_addr, 32'h24);
        chk("fl_drain_req",   {31'b0, imem_req}, 32'h1);
        chk("fl_drain_valid", {31'b0, if_id_valid}, 32'h0);
        flush = 1'b0; branch_target = 32'h0;
        step;
        chk("fl_wait_addr", imem_addr, 32'h24);
        ack_man = 1'b1; rd_ov_en = 1'b1; rd_ov = 16'hBEEF;
        step;
        chk("fl_redir_addr", imem_addr, 32'h100);
        chk("fl_late_valid", {31'b0, if_id_valid}, 32'h0);
        ack_man = 1'b0; rd_ov_en = 1'b0;
        step;
        chk("fl_late_instr", {16'b0, if_id_instr}, 32'h0022);
        ack_auto = 1'b1;
        step;
        chk("fl_tgt_pc",    if_id_pc, 32'h100);
        chk("fl_tgt_valid", {31'b0, if_id_valid}, 32'h1);

        // Flush and stall together: squash wins
        flush = 1'b1; stall = 1'b1; branch_target = 32'h200;
        step;
        chk("fs_valid", {31'b0, if_id_valid}, 32'h0);
        chk("fs_addr",  imem_addr, 32'h200);
        chk("fs_req",   {31'b0, imem_req}, 32'h1);
        flush = 1'b0; stall = 1'b0;
        step;
        chk("fs_tgt_pc", if_id_pc, 32'h200);

        // Register field extraction
        rd_ov_en = 1'b1; rd_ov = 16'h01C8;
        step;
        rd_ov_en = 1'b0;
        chk("rs_instr", {16'b0, if_id_instr}, 32'h01C8);
        chk("rs1", {28'b0, if_id_rs1}, 32'h1);
        chk("rs2", {28'b0, if_id_rs2}, 32'h7);

        // Reset pulse during DRAIN
        ack_auto = 1'b0; ack_man = 1'b0;
        flush = 1'b1; branch_target = 32'h300;
        step;
        chk("dr_addr", imem_addr, 32'h204);
        flush = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        step;
        rst_n = 1'b1; ack_auto = 1'b1;
        step;
        chk("rr_req",  {31'b0, imem_req}, 32'h1);
        chk("rr_addr", imem_addr, 32'h0);
        step;
        chk("rr_pc",    if_id_pc, 32'h0);
        chk("rr_valid", {31'b0, if_id_valid}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
